// File: rtl/mem_access_pkg.sv
// mem_access_pkg: size encodings, controller states and defaults shared by the memory access path.
package mem_access_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 15;
    typedef enum logic [1:0] {IDLE, ACCESS, RELEASE, FINISH} state_t;
    // The reserved size 2'b11 is handled as a word, so only SIZE[1] matters above halfword.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        return (size == SZ_HALF) ? lo[0] : (size[1] ? |lo : 1'b0);
    endfunction
endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: word-wide RAM bus with the MFA/MOC handshake.
interface mem_access_ctrl_if;
    logic        MEM_MFA;
    logic        MEM_RW;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic [3:0]  MEM_BE;
    logic [31:0] MEM_RDATA;
    logic        MEM_MOC;
    modport master(output MEM_MFA, MEM_RW, MEM_ADDR, MEM_WDATA, MEM_BE, input MEM_RDATA, MEM_MOC);
    modport slave(input MEM_MFA, MEM_RW, MEM_ADDR, MEM_WDATA, MEM_BE, output MEM_RDATA, MEM_MOC);
endinterface

// File: rtl/mem_lane_extract.sv
// mem_lane_extract: selects the addressed byte/halfword lane of a memory word and extends it to 32 bits.
module mem_lane_extract
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lo,
    input  logic [1:0]  size,
    input  logic        sgn,
    output logic [31:0] result
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    assign byte_sel = word[{lo, 3'b000} +: 8];
    assign half_sel = lo[1] ? word[31:16] : word[15:0];
    assign result = (size == SZ_BYTE) ? {{24{sgn & byte_sel[7]}}, byte_sel} :
                    (size == SZ_HALF) ? {{16{sgn & half_sel[15]}}, half_sel} : word;
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: turns a START strobe into an MFA/MOC memory cycle with sizing, lane steering,
// sign extension, MDR load pulse and misalignment/timeout reporting.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               START,
    input  logic               RW,
    input  logic [1:0]         SIZE,
    input  logic               SIGNED,
    input  logic [31:0]        ADDR,
    input  logic [31:0]        WDATA,
    mem_access_ctrl_if.master  mem,
    output logic [31:0]        RDATA,
    output logic               MDR_LOAD,
    output logic               BUSY,
    output logic               DONE,
    output logic               ALIGN_ERR,
    output logic               TIMEOUT_ERR
);
    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0]  size_q, size_d, lo_q, lo_d;
    logic        sgn_q, sgn_d;
    logic [31:0] rbuf_q, rbuf_d, rdata_q, rdata_d, ext;
    logic        rw_q, rw_d, mfa_q, mfa_d, busy_q, busy_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, wsteer;
    logic [3:0]  be_q, be_d, wbe;
    logic        mdr_q, mdr_d, done_q, done_d, aerr_q, aerr_d, terr_q, terr_d;

    mem_lane_extract u_extract (.word(rbuf_q), .lo(lo_q), .size(size_q), .sgn(sgn_q), .result(ext));

    assign wsteer = (SIZE == SZ_BYTE) ? {4{WDATA[7:0]}} : (SIZE == SZ_HALF) ? {2{WDATA[15:0]}} : WDATA;
    assign wbe = RW ? 4'hf : (SIZE == SZ_BYTE) ? 4'b0001 << ADDR[1:0] :
                 (SIZE == SZ_HALF) ? (ADDR[1] ? 4'b1100 : 4'b0011) : 4'hf;
    assign cnt_inc = cnt_q + 32'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        lo_d    = lo_q;
        sgn_d   = sgn_q;
        rbuf_d  = rbuf_q;
        rdata_d = rdata_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        mdr_d   = 1'b0;
        done_d  = 1'b0;
        aerr_d  = 1'b0;
        terr_d  = 1'b0;
        case (state_q)
            IDLE: if (START) begin
                if (misaligned(SIZE, ADDR[1:0])) aerr_d = 1'b1;
                else begin
                    state_d = ACCESS;
                    cnt_d   = 32'd0;
                    size_d  = SIZE;
                    lo_d    = ADDR[1:0];
                    sgn_d   = SIGNED;
                    rw_d    = RW;
                    addr_d  = {ADDR[31:2], 2'b00};
                    wdata_d = wsteer;
                    be_d    = wbe;
                end
            end
            ACCESS: if (mem.MEM_MOC) begin
                rbuf_d  = mem.MEM_RDATA;
                state_d = RELEASE;
            end else begin
                cnt_d = cnt_inc;
                if (TIMEOUT_CYCLES != 0 && cnt_inc == TIMEOUT_CYCLES) begin
                    terr_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            RELEASE: if (!mem.MEM_MOC) begin
                state_d = FINISH;
                done_d  = 1'b1;
                mdr_d   = rw_q;
                rdata_d = rw_q ? ext : rdata_q;
            end
            default: state_d = IDLE;
        endcase
        // Handshake and status flops look one state ahead so they change on the same edge as the state.
        mfa_d  = state_d == ACCESS;
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            size_q  <= SZ_WORD;
            lo_q    <= '0;
            sgn_q   <= 1'b0;
            rbuf_q  <= '0;
            rdata_q <= '0;
            rw_q    <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            mfa_q   <= 1'b0;
            busy_q  <= 1'b0;
            mdr_q   <= 1'b0;
            done_q  <= 1'b0;
            aerr_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            lo_q    <= lo_d;
            sgn_q   <= sgn_d;
            rbuf_q  <= rbuf_d;
            rdata_q <= rdata_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            mfa_q   <= mfa_d;
            busy_q  <= busy_d;
            mdr_q   <= mdr_d;
            done_q  <= done_d;
            aerr_q  <= aerr_d;
            terr_q  <= terr_d;
        end
    end

    assign mem.MEM_MFA   = mfa_q;
    assign mem.MEM_RW    = rw_q;
    assign mem.MEM_ADDR  = addr_q;
    assign mem.MEM_WDATA = wdata_q;
    assign mem.MEM_BE    = be_q;
    assign RDATA         = rdata_q;
    assign MDR_LOAD      = mdr_q;
    assign BUSY          = busy_q;
    assign DONE          = done_q;
    assign ALIGN_ERR     = aerr_q;
    assign TIMEOUT_ERR   = terr_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed vectors; expected completions and bus cycles are queued and checked by monitors.
module tb_mem_access_ctrl;
    import mem_access_pkg::*;
    localparam int K_DONE = 0, K_ALIGN = 1, K_TOUT = 2;
    typedef struct { logic [3:0] flags; logic [31:0] rdata; int at; } ev_t;
    typedef struct { logic rw; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; } bus_t;

    logic CLK = 0, RESET = 1, START = 0, RW = 0, SIGNED = 0;
    logic [1:0]  SIZE = 0;
    logic [31:0] ADDR = 0, WDATA = 0, RDATA;
    logic MDR_LOAD, BUSY, DONE, ALIGN_ERR, TIMEOUT_ERR;
    mem_access_ctrl_if m();

    mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .RW(RW), .SIZE(SIZE), .SIGNED(SIGNED),
        .ADDR(ADDR), .WDATA(WDATA), .mem(m), .RDATA(RDATA), .MDR_LOAD(MDR_LOAD), .BUSY(BUSY),
        .DONE(DONE), .ALIGN_ERR(ALIGN_ERR), .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    always #5 CLK = ~CLK;

    ev_t  ev_q[$], mon_e;
    bus_t bus_q[$], mon_b;
    int vectors = 0, errors = 0, cyc = 0;
    logic [31:0] rd_model = 0, mem_word = 0;
    int mem_delay = 0;
    logic mem_hang = 0, mfa_prev = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory: raises MOC with the programmed word after mem_delay MFA cycles, drops it once MFA falls.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        m.MEM_MOC = 0;
        m.MEM_RDATA = 0;
        forever begin
            @(negedge CLK);
            if (!m.MEM_MFA) begin
                m.MEM_MOC = 0;
                wait_cnt = 0;
            end else if (!m.MEM_MOC && !mem_hang) begin
                if (wait_cnt == mem_delay) begin
                    m.MEM_MOC = 1;
                    m.MEM_RDATA = mem_word;
                end else wait_cnt++;
            end
        end
    end

    always @(negedge CLK) begin
        if (DONE | MDR_LOAD | ALIGN_ERR | TIMEOUT_ERR) begin
            if (ev_q.size() == 0) check("unexpected_pulse", {28'd0, DONE, MDR_LOAD, ALIGN_ERR, TIMEOUT_ERR}, 0);
            else begin
                mon_e = ev_q.pop_front();
                check("pulses", {28'd0, DONE, MDR_LOAD, ALIGN_ERR, TIMEOUT_ERR}, {28'd0, mon_e.flags});
                check("rdata", RDATA, mon_e.rdata);
                check("cycle", cyc, mon_e.at);
                check("busy", {31'd0, BUSY}, {31'd0, mon_e.flags[3]});
                check("mfa_low", {31'd0, m.MEM_MFA}, 0);
            end
        end
        if (m.MEM_MFA && !mfa_prev) begin
            if (bus_q.size() == 0) check("unexpected_mfa", {31'd0, m.MEM_MFA}, 0);
            else begin
                mon_b = bus_q.pop_front();
                check("mem_rw", {31'd0, m.MEM_RW}, {31'd0, mon_b.rw});
                check("mem_addr", m.MEM_ADDR, mon_b.addr);
                check("mem_be", {28'd0, m.MEM_BE}, {28'd0, mon_b.be});
                if (!mon_b.rw) check("mem_wdata", m.MEM_WDATA, mon_b.wdata);
            end
        end
        mfa_prev = m.MEM_MFA;
    end

    task automatic wait_idle();
        for (int i = 0; i < 40 && (ev_q.size() != 0 || BUSY); i++) @(negedge CLK);
        if (ev_q.size() != 0) begin
            check("event_missing", ev_q.size(), 0);
            ev_q.delete();
        end
        if (bus_q.size() != 0) begin
            check("bus_missing", bus_q.size(), 0);
            bus_q.delete();
        end
    endtask

    task automatic run(input logic rw, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] mw, input int dly, input int kind,
                       input logic [31:0] eaddr, input logic [3:0] ebe, input logic [31:0] ewd,
                       input logic [31:0] erd);
        ev_t  e;
        bus_t b;
        @(negedge CLK);
        mem_word = mw;
        mem_delay = dly;
        mem_hang = (kind == K_TOUT);
        START = 1; RW = rw; SIZE = sz; SIGNED = sg; ADDR = a; WDATA = wd;
        if (kind == K_DONE && rw) rd_model = erd;
        e.rdata = rd_model;
        e.flags = (kind == K_ALIGN) ? 4'b0010 : (kind == K_TOUT) ? 4'b0001 : {1'b1, rw, 2'b00};
        e.at = cyc + ((kind == K_ALIGN) ? 1 : (kind == K_TOUT) ? 5 : dly + 3);
        ev_q.push_back(e);
        if (kind != K_ALIGN) begin
            b = '{rw, eaddr, ewd, ebe};
            bus_q.push_back(b);
        end
        @(negedge CLK);
        START = 0;
        wait_idle();
    endtask

    task automatic check_reset();
        check("rst_ctrl", {21'd0, m.MEM_MFA, m.MEM_RW, m.MEM_BE, MDR_LOAD, BUSY, DONE, ALIGN_ERR, TIMEOUT_ERR},
              32'h0000_0200);
        check("rst_addr", m.MEM_ADDR, 0);
        check("rst_wdata", m.MEM_WDATA, 0);
        check("rst_rdata", RDATA, 0);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check_reset();
        RESET = 0;
        //  rw  size   sg  addr          wdata         mem word      dly kind     eaddr         be    ewd           erd
        run(1, 2'b10, 0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 2, K_DONE,  32'h0000_0100, 4'hF, 32'h0,        32'hDEAD_BEEF);
        run(1, 2'b00, 1, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0, K_DONE,  32'h0000_0100, 4'hF, 32'h0,        32'hFFFF_FF80);
        run(1, 2'b00, 0, 32'h0000_0103, 32'h0,        32'h80FF_1234, 1, K_DONE,  32'h0000_0100, 4'hF, 32'h0,        32'h0000_0080);
        run(0, 2'b01, 0, 32'h0000_0202, 32'h0000_ABCD, 32'h0,        1, K_DONE,  32'h0000_0200, 4'hC, 32'hABCD_ABCD, 32'h0);
        run(0, 2'b00, 0, 32'h0000_0001, 32'h1234_5677, 32'h0,        3, K_DONE,  32'h0000_0000, 4'h2, 32'h7777_7777, 32'h0);
        run(0, 2'b00, 0, 32'h0000_0003, 32'h0000_00A5, 32'h0,        0, K_DONE,  32'h0000_0000, 4'h8, 32'hA5A5_A5A5, 32'h0);
        run(0, 2'b10, 0, 32'h0000_0040, 32'hCAFE_F00D, 32'h0,        0, K_DONE,  32'h0000_0040, 4'hF, 32'hCAFE_F00D, 32'h0);
        run(1, 2'b01, 1, 32'h0000_0002, 32'h0,        32'h8001_7FFF, 0, K_DONE,  32'h0000_0000, 4'hF, 32'h0,        32'hFFFF_8001);
        run(1, 2'b01, 1, 32'h0000_0000, 32'h0,        32'h8001_7FFF, 0, K_DONE,  32'h0000_0000, 4'hF, 32'h0,        32'h0000_7FFF);
        run(1, 2'b01, 0, 32'h0000_0006, 32'h0,        32'h8001_7FFF, 2, K_DONE,  32'h0000_0004, 4'hF, 32'h0,        32'h0000_8001);
        run(1, 2'b10, 0, 32'h0000_0101, 32'h0,        32'h0,         0, K_ALIGN, 32'h0,         4'h0, 32'h0,        32'h0);
        run(1, 2'b01, 0, 32'h0000_0003, 32'h0,        32'h0,         0, K_ALIGN, 32'h0,         4'h0, 32'h0,        32'h0);
        run(0, 2'b11, 0, 32'h0000_0002, 32'h1111_2222, 32'h0,        0, K_ALIGN, 32'h0,         4'h0, 32'h0,        32'h0);
        run(1, 2'b11, 1, 32'h0000_0010, 32'h0,        32'h1122_3344, 1, K_DONE,  32'h0000_0010, 4'hF, 32'h0,        32'h1122_3344);
        run(1, 2'b10, 0, 32'h0000_0020, 32'h0,        32'h0,         0, K_TOUT,  32'h0000_0020, 4'hF, 32'h0,        32'h0);
        // Abort an access with RESET while the memory never answers.
        @(negedge CLK);
        mem_hang = 1;
        START = 1; RW = 1; SIZE = 2'b10; SIGNED = 0; ADDR = 32'h0000_0080;
        bus_q.push_back('{1'b1, 32'h0000_0080, 32'h0, 4'hF});
        @(negedge CLK);
        START = 0;
        @(negedge CLK);
        RESET = 1;
        @(negedge CLK);
        check_reset();
        RESET = 0;
        rd_model = 0;
        wait_idle();
        run(1, 2'b10, 0, 32'h0000_0300, 32'h0,        32'h0102_0304, 2, K_DONE,  32'h0000_0300, 4'hF, 32'h0,        32'h0102_0304);
        repeat (3) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
        $fatal(1);
    end
endmodule
